// File: rtl/axil_pkg.sv
// Shared definitions for the AXI-Lite master bridge.
//   state_e      : bridge FSM states
//   RESP_*       : AXI-Lite response codes
//   PROT_DEFAULT : protection attribute driven on AW/AR
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    READ_A,
    READ_D,
    DONE
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_master_bridge.sv
// CPU valid/ready memory port to AXI-Lite master bridge, one transaction
// outstanding at a time.
//   aclk, aresetn      : clock, async active-low reset
//   mem_*              : CPU side (wstrb==0 is a read, mem_ready is a 1-cycle pulse)
//   m_axil_aw*/w*/b*   : AXI-Lite write address / data / response channels
//   m_axil_ar*/r*      : AXI-Lite read address / data channels
//
// state  | meaning
// IDLE   | waiting for a CPU request (not while mem_ready is pulsing)
// WRITE  | AW and W presented; each valid drops on its own handshake
// WRESP  | bready high, waiting for the write response
// READ_A | arvalid high, waiting for arready
// READ_D | rready high, waiting for read data
// DONE   | response captured; mem_ready pulses on leaving this state
module axil_master_bridge
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [STRB_WIDTH-1:0] mem_wstrb,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_err,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  bready_q, bready_d;
  logic                  rready_q, rready_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  mem_ready_q, mem_ready_d;
  logic                  mem_err_q, mem_err_d;

  logic aw_hs, w_hs;

  assign aw_hs = awvalid_q && m_axil_awready;
  assign w_hs  = wvalid_q && m_axil_wready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    mem_ready_d = 1'b0;
    mem_err_d   = mem_err_q;

    case (state_q)
      IDLE: begin
        // mem_ready_q high means the CPU is still seeing the previous
        // completion and has not yet dropped mem_valid.
        if (mem_valid && !mem_ready_q) begin
          addr_d    = mem_addr;
          wdata_d   = mem_wdata;
          wstrb_d   = mem_wstrb;
          mem_err_d = 1'b0;
          if (|mem_wstrb) begin
            state_d   = WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = READ_A;
            arvalid_d = 1'b1;
          end
        end
      end
      WRITE: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d   = WRESP;
          bready_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WRESP: begin
        if (bready_q && m_axil_bvalid) begin
          mem_err_d = (m_axil_bresp != RESP_OKAY);
          bready_d  = 1'b0;
          state_d   = DONE;
        end
      end
      READ_A: begin
        if (arvalid_q && m_axil_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = READ_D;
        end
      end
      READ_D: begin
        if (rready_q && m_axil_rvalid) begin
          rdata_d   = m_axil_rdata;
          mem_err_d = (m_axil_rresp != RESP_OKAY);
          rready_d  = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        mem_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      mem_ready_q <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      mem_ready_q <= mem_ready_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign mem_ready      = mem_ready_q;
  assign mem_rdata      = rdata_q;
  assign mem_err        = mem_err_q;
  assign m_axil_awaddr  = addr_q;
  assign m_axil_awprot  = PROT_DEFAULT;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_arprot  = PROT_DEFAULT;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_axil_master_bridge.sv
module tb_axil_master_bridge;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic [31:0] m_awaddr, m_wdata, m_araddr;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;

  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axil_master_bridge dut (
    .aclk(aclk), .aresetn(aresetn),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .m_axil_awaddr(m_awaddr), .m_axil_awprot(m_awprot), .m_axil_awvalid(m_awvalid),
    .m_axil_awready(s_awready),
    .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb), .m_axil_wvalid(m_wvalid),
    .m_axil_wready(s_wready),
    .m_axil_bresp(s_bresp), .m_axil_bvalid(s_bvalid), .m_axil_bready(m_bready),
    .m_axil_araddr(m_araddr), .m_axil_arprot(m_arprot), .m_axil_arvalid(m_arvalid),
    .m_axil_arready(s_arready),
    .m_axil_rdata(s_rdata), .m_axil_rresp(s_rresp), .m_axil_rvalid(s_rvalid),
    .m_axil_rready(m_rready)
  );

  // ---------------- AXI-Lite memory slave model ----------------
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic        always_rdy = 1'b1;
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;

  logic        aw_have, w_have, ar_have;
  logic [31:0] aw_addr_l, w_data_l, ar_addr_l;
  logic [3:0]  w_strb_l;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  int          aw_hs_cnt = 0, w_hs_cnt = 0, ar_hs_cnt = 0;
  logic [31:0] last_awaddr = '0, last_wdata = '0;
  logic [3:0]  last_wstrb = '0;
  logic [2:0]  last_prot = '0;

  logic        t_aw, t_w, t_ar;
  logic [31:0] t_aa, t_wd, t_ra;
  logic [3:0]  t_ws;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) o[i*8 +: 8] = d[i*8 +: 8];
    return o;
  endfunction

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_awready <= 1'b0; s_wready <= 1'b0; s_bvalid <= 1'b0;
      s_arready <= 1'b0; s_rvalid <= 1'b0;
      s_bresp <= 2'b00; s_rresp <= 2'b00; s_rdata <= '0;
      aw_have <= 1'b0; w_have <= 1'b0; ar_have <= 1'b0;
      aw_addr_l <= '0; w_data_l <= '0; w_strb_l <= '0; ar_addr_l <= '0;
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
    end else begin
      t_aw = aw_have; t_aa = aw_addr_l;
      t_w = w_have; t_wd = w_data_l; t_ws = w_strb_l;
      t_ar = ar_have; t_ra = ar_addr_l;
      if (m_awvalid && s_awready) begin
        t_aw = 1'b1; t_aa = m_awaddr; aw_hs_cnt <= aw_hs_cnt + 1;
        last_awaddr <= m_awaddr; last_prot <= m_awprot;
      end
      if (m_wvalid && s_wready) begin
        t_w = 1'b1; t_wd = m_wdata; t_ws = m_wstrb; w_hs_cnt <= w_hs_cnt + 1;
        last_wdata <= m_wdata; last_wstrb <= m_wstrb;
      end
      if (m_arvalid && s_arready) begin
        t_ar = 1'b1; t_ra = m_araddr; ar_hs_cnt <= ar_hs_cnt + 1;
      end

      if (s_bvalid && m_bready) s_bvalid <= 1'b0;
      else if (t_aw && t_w && !s_bvalid) begin
        if (b_cnt >= b_dly) begin
          if (bresp_cfg == 2'b00) mem[t_aa[9:2]] = merge(mem[t_aa[9:2]], t_wd, t_ws);
          s_bvalid <= 1'b1; s_bresp <= bresp_cfg; b_cnt <= 0;
          t_aw = 1'b0; t_w = 1'b0;
        end else b_cnt <= b_cnt + 1;
      end

      if (s_rvalid && m_rready) s_rvalid <= 1'b0;
      else if (t_ar && !s_rvalid) begin
        if (r_cnt >= r_dly) begin
          s_rvalid <= 1'b1; s_rdata <= mem[t_ra[9:2]]; s_rresp <= rresp_cfg; r_cnt <= 0;
          t_ar = 1'b0;
        end else r_cnt <= r_cnt + 1;
      end

      if (always_rdy) s_awready <= 1'b1;
      else if (m_awvalid && !s_awready && !t_aw) begin
        if (aw_cnt >= aw_dly) begin s_awready <= 1'b1; aw_cnt <= 0; end
        else aw_cnt <= aw_cnt + 1;
      end else s_awready <= 1'b0;

      if (always_rdy) s_wready <= 1'b1;
      else if (m_wvalid && !s_wready && !t_w) begin
        if (w_cnt >= w_dly) begin s_wready <= 1'b1; w_cnt <= 0; end
        else w_cnt <= w_cnt + 1;
      end else s_wready <= 1'b0;

      if (always_rdy) s_arready <= 1'b1;
      else if (m_arvalid && !s_arready && !t_ar) begin
        if (ar_cnt >= ar_dly) begin s_arready <= 1'b1; ar_cnt <= 0; end
        else ar_cnt <= ar_cnt + 1;
      end else s_arready <= 1'b0;

      aw_have <= t_aw; aw_addr_l <= t_aa;
      w_have <= t_w; w_data_l <= t_wd; w_strb_l <= t_ws;
      ar_have <= t_ar; ar_addr_l <= t_ra;
    end
  end

  // ---------------- protocol monitor ----------------
  logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      p_awv <= 1'b0; p_awr <= 1'b0; p_wv <= 1'b0; p_wr <= 1'b0; p_arv <= 1'b0; p_arr <= 1'b0;
      p_awaddr <= '0; p_wdata <= '0; p_araddr <= '0; p_wstrb <= '0;
    end else begin
      if (p_awv && !p_awr && (!m_awvalid || m_awaddr !== p_awaddr)) begin
        errors++; $display("FAIL aw_stable: awvalid=%0b awaddr=%h required 1/%h", m_awvalid, m_awaddr, p_awaddr);
      end
      if (p_wv && !p_wr && (!m_wvalid || m_wdata !== p_wdata || m_wstrb !== p_wstrb)) begin
        errors++; $display("FAIL w_stable: wvalid=%0b wdata=%h required 1/%h", m_wvalid, m_wdata, p_wdata);
      end
      if (p_arv && !p_arr && (!m_arvalid || m_araddr !== p_araddr)) begin
        errors++; $display("FAIL ar_stable: arvalid=%0b araddr=%h required 1/%h", m_arvalid, m_araddr, p_araddr);
      end
      if ((m_awvalid || m_wvalid || m_bready) && (m_arvalid || m_rready)) begin
        errors++; $display("FAIL outstanding: write and read channels active together");
      end
      p_awv <= m_awvalid; p_awr <= s_awready; p_awaddr <= m_awaddr;
      p_wv <= m_wvalid; p_wr <= s_wready; p_wdata <= m_wdata; p_wstrb <= m_wstrb;
      p_arv <= m_arvalid; p_arr <= s_arready; p_araddr <= m_araddr;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] last_read = '0;

  task automatic cpu_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input bit chk_lat);
    exp_t e;
    exp_t got;
    int   cyc;
    int   aw0, w0, ar0;
    if (s == 4'b0) begin
      e.rdata = ref_mem[a[9:2]];
      e.err   = (rresp_cfg != 2'b00);
      last_read = e.rdata;
    end else begin
      e.rdata = last_read;
      e.err   = (bresp_cfg != 2'b00);
      if (bresp_cfg == 2'b00) ref_mem[a[9:2]] = merge(ref_mem[a[9:2]], d, s);
    end
    sb.push_back(e);
    aw0 = aw_hs_cnt; w0 = w_hs_cnt; ar0 = ar_hs_cnt;
    @(negedge aclk);
    mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_valid = 1'b1;
    cyc = 0;
    do begin
      @(negedge aclk);
      cyc++;
    end while (!mem_ready && cyc < 300);
    got = sb.pop_front();
    checks++;
    if (!mem_ready) begin
      errors++; $display("FAIL timeout: addr=%h no mem_ready after %0d cycles", a, cyc);
    end else begin
      checks++;
      if (mem_rdata !== got.rdata) begin
        errors++; $display("FAIL rdata: addr=%h got %h required %h", a, mem_rdata, got.rdata);
      end
      checks++;
      if (mem_err !== got.err) begin
        errors++; $display("FAIL err: addr=%h got %0b required %0b", a, mem_err, got.err);
      end
      if (chk_lat) begin
        checks++;
        if (cyc - 1 != 3) begin
          errors++; $display("FAIL latency: got %0d required 3", cyc - 1);
        end
      end
    end
    mem_valid = 1'b0;
    @(negedge aclk);
    checks++;
    if (mem_ready !== 1'b0) begin
      errors++; $display("FAIL pulse: mem_ready still %0b required 0", mem_ready);
    end
    checks++;
    if ((aw_hs_cnt - aw0) != ((s != 0) ? 1 : 0) || (w_hs_cnt - w0) != ((s != 0) ? 1 : 0) ||
        (ar_hs_cnt - ar0) != ((s == 0) ? 1 : 0)) begin
      errors++; $display("FAIL handshakes: aw=%0d w=%0d ar=%0d for wstrb=%b",
                         aw_hs_cnt - aw0, w_hs_cnt - w0, ar_hs_cnt - ar0, s);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    checks++;
    if ({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, mem_ready, mem_err} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b required 0000000",
                         {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, mem_ready, mem_err});
    end
    checks++;
    if (mem_rdata !== 32'h0 || m_awaddr !== 32'h0 || m_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_data: rdata=%h addr=%h wdata=%h required 0", mem_rdata, m_awaddr, m_wdata);
    end
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_read();
    always_rdy = 1'b1;
    mem[8'h40] = 32'hDEADBEEF;
    ref_mem[8'h40] = 32'hDEADBEEF;
    cpu_req(32'h100, 32'h0, 4'b0000, 1'b1);
    checks++;
    if (mem_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_const: got %h required deadbeef", mem_rdata);
    end
  endtask

  task automatic test_write();
    mem[2] = 32'hAABBCCDD;
    ref_mem[2] = 32'hAABBCCDD;
    cpu_req(32'h8, 32'h11223344, 4'b0101, 1'b1);
    checks++;
    if (last_awaddr !== 32'h8 || last_wdata !== 32'h11223344 || last_wstrb !== 4'b0101 || last_prot !== 3'b000) begin
      errors++; $display("FAIL aw_w_payload: addr=%h data=%h strb=%b prot=%b", last_awaddr, last_wdata, last_wstrb, last_prot);
    end
    cpu_req(32'h8, 32'h0, 4'b0000, 1'b0);
    checks++;
    if (mem_rdata !== 32'hAA22CC44) begin
      errors++; $display("FAIL write_merge: got %h required aa22cc44", mem_rdata);
    end
  endtask

  task automatic test_backpressure();
    always_rdy = 1'b0;
    aw_dly = 3; w_dly = 1; b_dly = 2;
    cpu_req(32'h10, 32'hCAFEF00D, 4'b1111, 1'b0);
    aw_dly = 1; w_dly = 3; b_dly = 0;
    cpu_req(32'h14, 32'h12345678, 4'b1100, 1'b0);
    ar_dly = 2; r_dly = 3;
    cpu_req(32'h10, 32'h0, 4'b0000, 1'b0);
    cpu_req(32'h14, 32'h0, 4'b0000, 1'b0);
    aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0;
  endtask

  task automatic test_errors();
    always_rdy = 1'b1;
    bresp_cfg = 2'b10;
    cpu_req(32'h30, 32'hFFFFFFFF, 4'b1111, 1'b0);
    bresp_cfg = 2'b00;
    rresp_cfg = 2'b11;
    cpu_req(32'h100, 32'h0, 4'b0000, 1'b0);
    rresp_cfg = 2'b00;
    cpu_req(32'h30, 32'h0, 4'b0000, 1'b0);
    cpu_req(32'h34, 32'h01020304, 4'b0011, 1'b0);
  endtask

  task automatic test_async_reset();
    int seen;
    always_rdy = 1'b0;
    aw_dly = 10; w_dly = 0;
    @(negedge aclk);
    mem_addr = 32'h20; mem_wdata = 32'h55555555; mem_wstrb = 4'b1111; mem_valid = 1'b1;
    repeat (3) @(negedge aclk);
    checks++;
    if (m_awvalid !== 1'b1) begin
      errors++; $display("FAIL abort_setup: awvalid=%0b required 1", m_awvalid);
    end
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if ({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, mem_ready} !== 6'b0) begin
      errors++; $display("FAIL abort_ctrl: got %b required 000000",
                         {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, mem_ready});
    end
    mem_valid = 1'b0;
    last_read = 32'h0;
    @(negedge aclk);
    aresetn = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge aclk);
      if (mem_ready) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL spurious_ready: got %0d pulses required 0", seen);
    end
    aw_dly = 0;
    always_rdy = 1'b1;
    cpu_req(32'h20, 32'h0, 4'b0000, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, d;
    logic [3:0]  s;
    always_rdy = 1'b0;
    for (int i = 0; i < 30; i++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      a = {24'h0, 2'b01, 4'($urandom_range(0, 15)), 2'b00};
      d = $urandom;
      s = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
      cpu_req(a, d, s, 1'b0);
    end
    always_rdy = 1'b1;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_backpressure();
    test_errors();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axil_master_bridge.md
Name: axil_master_bridge

Overview:
- Converts the CPU's native valid/ready memory port (address, wdata, wstrb; wstrb==0 means read) into single AXI-Lite transactions, acting as the initiator.
- It is the master end of the AXI-Lite bus that feeds the interconnect and the AXI-Lite memory/peripheral slaves.
- Exactly one transaction is outstanding at a time. Responses are returned to the CPU with a one-cycle mem_ready pulse.

Parameters:
- ADDR_WIDTH, 32, address width on both sides.
- DATA_WIDTH, 32, data width on both sides.
- STRB_WIDTH, DATA_WIDTH/8, byte-strobe width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset. One clock; reset is asynchronous and active-low.
- mem_valid  in  1  CPU request valid; held by the CPU until mem_ready.
- mem_ready  out  1  one-cycle completion pulse.
- mem_addr  in  ADDR_WIDTH  byte address.
- mem_wdata  in  DATA_WIDTH  write data.
- mem_wstrb  in  STRB_WIDTH  byte enables; all-zero = read.
- mem_rdata  out  DATA_WIDTH  read data, valid while mem_ready.
- mem_err  out  1  response was not OKAY, valid while mem_ready.
- m_axil_awaddr/awprot/awvalid  out  ADDR_WIDTH/3/1  write address channel.
- m_axil_awready  in  1  write address channel ready.
- m_axil_wdata/wstrb/wvalid  out  DATA_WIDTH/STRB_WIDTH/1  write data channel.
- m_axil_wready  in  1  write data channel ready.
- m_axil_bresp/bvalid  in  2/1  write response channel.
- m_axil_bready  out  1  write response channel ready.
- m_axil_araddr/arprot/arvalid  out  ADDR_WIDTH/3/1  read address channel.
- m_axil_arready  in  1  read address channel ready.
- m_axil_rdata/rresp/rvalid  in  DATA_WIDTH/2/1  read data channel.
- m_axil_rready  out  1  read data channel ready.

Behaviour:
- Reset (async, aresetn=0):
  - state=IDLE.
  - awvalid, wvalid, arvalid, bready, rready, mem_ready, mem_err all 0.
  - mem_rdata = 0.
  - Address/data registers cleared.
  - Applies immediately mid-transaction. No completion is reported for an aborted request.
- All outputs are registered. prot is always 3'b000. Addresses are passed through unmodified (no alignment, no OFFSET).
- IDLE, on mem_valid && !mem_ready:
  - Latch addr, wdata, wstrb.
  - If wstrb!=0: go to WRITE and set awvalid=wvalid=1 on the next edge.
  - Else: go to READ_A with arvalid=1.
- WRITE:
  - awvalid drops on the edge where awvalid&&awready; wvalid drops independently on wvalid&&wready.
  - Both may complete in the same cycle, or in either order.
  - A valid is never deasserted before its handshake. awaddr, wdata and wstrb are stable while the corresponding valid is high.
  - When both are done, go to WRESP with bready=1.
- WRESP: on bvalid&&bready, capture mem_err=(bresp!=2'b00), drop bready, go to DONE.
- READ_A: on arvalid&&arready, drop arvalid, set rready=1, go to READ_D.
- READ_D: on rvalid&&rready, capture mem_rdata=rdata and mem_err=(rresp!=2'b00), drop rready, go to DONE.
- DONE:
  - mem_ready=1 for exactly one cycle; mem_rdata and mem_err are held stable through that cycle.
  - Then go to IDLE.
  - mem_rdata keeps its last read value after writes; mem_err is cleared on the next request.
- IDLE does not accept on the cycle mem_ready is high. The CPU drops mem_valid after seeing mem_ready.
- Minimum latency with always-ready slaves: request sampled at edge 0, AW/W handshake at edge 1, B handshake at edge 2, mem_ready high after edge 3.
- Ready inputs asserted while the corresponding valid is low are ignored.
- bvalid/rvalid arriving early (before bready/rready) is held by the slave per AXI and is consumed on entry to WRESP/READ_D.
- mem_valid dropping mid-transaction is a CPU protocol error. The bridge still completes the AXI transaction, and DONE is reported anyway.
- No timeout. A hung slave stalls the bridge until reset.

Decomposition:
- Package axil_pkg holds:
  - state enum {IDLE, WRITE, WRESP, READ_A, READ_D, DONE};
  - response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - PROT_DEFAULT=3'b000.
- No sub-module; a single FSM with two "done" flags for AW/W.

Test Plan:
- Read, always-ready slave, memory[0x40]=0xDEADBEEF: mem_valid, addr=0x100, wstrb=0 -> araddr=0x100; mem_rdata=0xDEADBEEF, mem_err=0, mem_ready a single pulse 3 cycles after request.
- Write wstrb=4'b0101, wdata=0x11223344, addr=0x8 -> one AW and one W with matching values; subsequent read returns only bytes 0 and 2 updated; mem_ready one pulse.
- Slave backpressure: awready delayed 3 cycles, wready delayed 1 cycle (and the reverse order) -> valids held, payload stable, no duplicate handshakes, completion after B.
- Error: slave returns bresp=2'b10 on a write, rresp=2'b11 on a read -> mem_err=1 during each mem_ready pulse; next OKAY transaction -> mem_err=0.
- Async reset asserted while in WRITE with awvalid high -> all valids/readies 0 immediately; after release, state IDLE, no spurious mem_ready; next read completes normally.
- Back-to-back read/write/read with randomized ready/valid delays against the AXI-Lite memory model -> all data matches a scoreboard; assertions: valid never drops before ready, at most one outstanding transaction.
